// File: rtl/video_system_input_pio_irq.sv
// Avalon-MM input PIO with synchroniser, per-bit edge capture, irq mask and level irq.
// Define PIO_DEBOUNCE_EN to add a per-bit stable-count debouncer after the synchroniser.
module video_system_input_pio_irq #(
   parameter int WIDTH           = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int EDGE_TYPE       = 0,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   input  logic [WIDTH-1:0]  in_port,
   output logic              irq
);

   localparam logic [2:0] PRIME_CYCLES = 3'(SYNC_STAGES + 1);
   localparam logic [1:0] EDGE_SEL     = 2'(EDGE_TYPE);

   logic [WIDTH-1:0] sync_r [SYNC_STAGES];
   logic [WIDTH-1:0] s_s;
   logic [WIDTH-1:0] value_s;
   logic [WIDTH-1:0] prev_r;
   logic [WIDTH-1:0] irq_mask_r;
   logic [WIDTH-1:0] edge_capture_r;
   logic [WIDTH-1:0] raw_edge_s;
   logic [WIDTH-1:0] edge_s;
   logic [WIDTH-1:0] clear_s;
   logic [WIDTH-1:0] mask_nxt_s;
   logic [WIDTH-1:0] capture_nxt_s;
   logic [2:0]       prime_cnt_r;
   logic             primed_s;
   logic             wr_s;
   logic [31:0]      read_mux_s;
   logic [31:0]      readdata_r;
   logic             irq_r;

   assign s_s      = sync_r[SYNC_STAGES-1];
   assign readdata = readdata_r;
   assign irq      = irq_r;

   // Synchroniser chain for the asynchronous inputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= {WIDTH{1'b0}};
      end else begin
         sync_r[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
      end
   end

`ifdef PIO_DEBOUNCE_EN
   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

   logic [CNT_W-1:0] db_cnt_r [WIDTH];
   logic [WIDTH-1:0] stable_r;

   // A bit is accepted once it has differed from the stable copy for DEBOUNCE_CYCLES cycles
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stable_r <= {WIDTH{1'b0}};
         for (int i = 0; i < WIDTH; i++) db_cnt_r[i] <= {CNT_W{1'b0}};
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (s_s[i] == stable_r[i]) begin
               db_cnt_r[i] <= {CNT_W{1'b0}};
            end else if ((db_cnt_r[i] + CNT_W'(1'b1)) == DB_LIMIT) begin
               stable_r[i] <= s_s[i];
               db_cnt_r[i] <= {CNT_W{1'b0}};
            end else begin
               db_cnt_r[i] <= db_cnt_r[i] + CNT_W'(1'b1);
            end
         end
      end
   end

   assign value_s = stable_r;
`else
   localparam int db_cycles_unused = DEBOUNCE_CYCLES;

   assign value_s = s_s;
`endif

   generate
      if (WIDTH < 32) begin : g_unused_wd
         logic unused_wd_s;
         assign unused_wd_s = ^writedata[31:WIDTH];
      end
   endgenerate

   assign wr_s     = chipselect & ~write_n;
   assign primed_s = (prime_cnt_r == PRIME_CYCLES);

   // Edge detection, gated off until the synchroniser has flushed after reset
   always_comb begin
      case (EDGE_SEL)
         2'd0:    raw_edge_s = value_s & ~prev_r;
         2'd1:    raw_edge_s = ~value_s & prev_r;
         default: raw_edge_s = value_s ^ prev_r;
      endcase
      if (primed_s) begin
         edge_s = raw_edge_s;
      end else begin
         edge_s = {WIDTH{1'b0}};
      end
   end

   // Next-state for mask and capture; a new edge beats a simultaneous write-1-to-clear
   always_comb begin
      if (wr_s && (address == 2'd1)) begin
         mask_nxt_s = writedata[WIDTH-1:0];
      end else begin
         mask_nxt_s = irq_mask_r;
      end
      if (wr_s && (address == 2'd3)) begin
         clear_s = writedata[WIDTH-1:0];
      end else begin
         clear_s = {WIDTH{1'b0}};
      end
      capture_nxt_s = (edge_capture_r & ~clear_s) | edge_s;
   end

   // Read multiplexer, zero-extended to the bus width
   always_comb begin
      read_mux_s = 32'd0;
      case (address)
         2'd0:    read_mux_s[WIDTH-1:0] = value_s;
         2'd1:    read_mux_s[WIDTH-1:0] = irq_mask_r;
         2'd3:    read_mux_s[WIDTH-1:0] = edge_capture_r;
         default: read_mux_s = 32'd0;
      endcase
   end

   // Register state, priming counter and registered outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         prev_r         <= {WIDTH{1'b0}};
         irq_mask_r     <= {WIDTH{1'b0}};
         edge_capture_r <= {WIDTH{1'b0}};
         prime_cnt_r    <= 3'd0;
         readdata_r     <= 32'd0;
         irq_r          <= 1'b0;
      end else begin
         prev_r         <= value_s;
         irq_mask_r     <= mask_nxt_s;
         edge_capture_r <= capture_nxt_s;
         if (!primed_s) begin
            prime_cnt_r <= prime_cnt_r + 3'd1;
         end else begin
            prime_cnt_r <= prime_cnt_r;
         end
         readdata_r     <= read_mux_s;
         irq_r          <= |(capture_nxt_s & mask_nxt_s);
      end
   end

endmodule
